// File: rtl/iterative_shifter_pkg.sv
// Shared encodings for the iterative shifter: operation codes, FSM states and step size.
// Rotate support is enabled by defining ITERATIVE_SHIFTER_ROTATE_EN.
package iterative_shifter_pkg;

   typedef enum logic [1:0] {
      OP_SLL  = 2'b00,
      OP_SRL  = 2'b01,
      OP_SRA  = 2'b10,
      OP_ROTL = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam int unsigned STEP_MAX = 2;

endpackage

// File: rtl/iterative_shifter_shift_step.sv
// One shift step of 1 or 2 bit positions for the iterative shifter datapath.
// Defining ITERATIVE_SHIFTER_ROTATE_EN adds the rotate-left wrap path; otherwise ROTL acts as SLL.
module shift_step
   import iterative_shifter_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] acc,
   input  op_e               op,
   input  logic [1:0]        step,
   output logic [DATA_W-1:0] next_acc
);

   // Any step value other than 1 or 2 leaves the accumulator unchanged.
   always_comb begin
      next_acc = acc;
      if (step == 2'd2) begin
         case (op)
            OP_SRL:  next_acc = {2'b00, acc[DATA_W-1:2]};
            OP_SRA:  next_acc = {{2{acc[DATA_W-1]}}, acc[DATA_W-1:2]};
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
            OP_ROTL: next_acc = {acc[DATA_W-3:0], acc[DATA_W-1:DATA_W-2]};
`endif
            default: next_acc = {acc[DATA_W-3:0], 2'b00};
         endcase
      end else if (step == 2'd1) begin
         case (op)
            OP_SRL:  next_acc = {1'b0, acc[DATA_W-1:1]};
            OP_SRA:  next_acc = {acc[DATA_W-1], acc[DATA_W-1:1]};
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
            OP_ROTL: next_acc = {acc[DATA_W-2:0], acc[DATA_W-1]};
`endif
            default: next_acc = {acc[DATA_W-2:0], 1'b0};
         endcase
      end
   end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle SLL/SRL/SRA shifter consuming up to two bit positions per cycle, start/done handshake.
// Optional rotate-left on op 11 when ITERATIVE_SHIFTER_ROTATE_EN is defined.
module iterative_shifter
   import iterative_shifter_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [1:0]         op_i,
   input  logic [DATA_W-1:0]  data_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [DATA_W-1:0]  data_o
);

   state_e               state_q, state_d;
   logic [DATA_W-1:0]    acc_q, acc_d, step_acc;
   logic [SHAMT_W-1:0]   cnt_q, cnt_d;
   op_e                  op_q, op_d;
   logic [1:0]           step;

   assign step = (cnt_q >= SHAMT_W'(STEP_MAX)) ? 2'(STEP_MAX) : 2'd1;

   shift_step #(.DATA_W(DATA_W)) u_step (
      .acc      (acc_q),
      .op       (op_q),
      .step     (step),
      .next_acc (step_acc)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         op_q    <= OP_SLL;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
      end
   end

   // A new start is accepted in DONE as well as IDLE so operations can run back to back.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      case (state_q)
         ST_SHIFT: begin
            acc_d   = step_acc;
            cnt_d   = cnt_q - {{(SHAMT_W-2){1'b0}}, step};
            state_d = (cnt_d == '0) ? ST_DONE : ST_SHIFT;
         end
         default: begin
            if (start_i) begin
               acc_d   = data_i;
               cnt_d   = shamt_i;
               op_d    = op_e'(op_i);
               state_d = (shamt_i != '0) ? ST_SHIFT : ST_DONE;
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   assign busy_o = (state_q == ST_SHIFT);
   assign done_o = (state_q == ST_DONE);
   assign data_o = acc_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Self-checking bench for iterative_shifter: directed cases plus randomized ops against an arithmetic model.
// Honors ITERATIVE_SHIFTER_ROTATE_EN in the reference model.
module tb_iterative_shifter;

   logic        clk_i   = 1'b0;
   logic        rst_i   = 1'b0;
   logic        start_i = 1'b0;
   logic [1:0]  op_i    = '0;
   logic [31:0] data_i  = '0;
   logic [4:0]  shamt_i = '0;
   logic        busy_o;
   logic        done_o;
   logic [31:0] data_o;

   int checks = 0;
   int passed = 0;

   always #5 clk_i = ~clk_i;

   iterative_shifter dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (start_i),
      .op_i    (op_i),
      .data_i  (data_i),
      .shamt_i (shamt_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .data_o  (data_o)
   );

   function automatic logic [31:0] ref_shift(logic [1:0] op, logic [31:0] d, int s);
      case (op)
         2'b01:   return d >> s;
         2'b10:   return 32'($signed(d) >>> s);
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
         2'b11:   return (d << s) | (d >> (32 - s));
`endif
         default: return d << s;
      endcase
   endfunction

   task automatic check_output(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic apply_stimulus(logic [1:0] op, logic [31:0] d, logic [4:0] s);
      start_i = 1'b1;
      op_i    = op;
      data_i  = d;
      shamt_i = s;
   endtask

   // Waits from the accepting edge until done_o; optionally keeps start_i high with junk while busy.
   task automatic wait_done(string tag, logic [1:0] op, logic [31:0] d, int s, bit hold);
      int lat    = 1 + (s + 1) / 2;
      int edges  = 0;
      int busy_n = 0;
      bit seen   = 1'b0;
      @(posedge clk_i); #1;
      edges   = 1;
      start_i = 1'b0;
      while (edges < 40) begin
         if (done_o) begin
            seen = 1'b1;
            break;
         end
         if (busy_o) busy_n++;
         if (hold && edges < lat) begin
            start_i = 1'b1;
            op_i    = 2'($urandom);
            data_i  = $urandom;
            shamt_i = 5'($urandom);
         end else begin
            start_i = 1'b0;
         end
         @(posedge clk_i); #1;
         edges++;
      end
      start_i = 1'b0;
      check_output({tag, " done seen"}, 32'(seen), 32'd1);
      check_output({tag, " latency"}, 32'(edges), 32'(lat));
      check_output({tag, " busy cycles"}, 32'(busy_n), 32'((s + 1) / 2));
      check_output({tag, " busy in done"}, 32'(busy_o), 32'd0);
      check_output({tag, " data"}, data_o, ref_shift(op, d, s));
   endtask

   task automatic idle_gap(string tag);
      @(posedge clk_i); #1;
      check_output({tag, " done pulse ends"}, 32'(done_o), 32'd0);
      check_output({tag, " idle busy"}, 32'(busy_o), 32'd0);
   endtask

   initial begin
      logic [1:0]  r_op;
      logic [31:0] r_data;
      logic [4:0]  r_shamt;
      bit          r_hold;
      bit          chained;
      bit          saw_done;

      #12;
      check_output("reset busy", 32'(busy_o), 32'd0);
      check_output("reset done", 32'(done_o), 32'd0);
      check_output("reset data", data_o, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i); #1;

      $display("[TB] SLL 1 by 31");
      apply_stimulus(2'b00, 32'h0000_0001, 5'd31);
      wait_done("sll31", 2'b00, 32'h0000_0001, 31, 1'b0);
      check_output("sll31 const", data_o, 32'h8000_0000);
      idle_gap("sll31");

      $display("[TB] SRA/SRL by 3");
      apply_stimulus(2'b10, 32'h8000_00F0, 5'd3);
      wait_done("sra3", 2'b10, 32'h8000_00F0, 3, 1'b0);
      check_output("sra3 const", data_o, 32'hF000_001E);
      idle_gap("sra3");
      apply_stimulus(2'b01, 32'h8000_00F0, 5'd3);
      wait_done("srl3", 2'b01, 32'h8000_00F0, 3, 1'b0);
      check_output("srl3 const", data_o, 32'h1000_001E);
      idle_gap("srl3");

      $display("[TB] shamt 0");
      apply_stimulus(2'b00, 32'hDEAD_BEEF, 5'd0);
      wait_done("sh0", 2'b00, 32'hDEAD_BEEF, 0, 1'b0);
      check_output("sh0 const", data_o, 32'hDEAD_BEEF);
      idle_gap("sh0");

      $display("[TB] start held while busy, then back-to-back start in DONE");
      apply_stimulus(2'b01, 32'hCAFE_0123, 5'd9);
      wait_done("hold", 2'b01, 32'hCAFE_0123, 9, 1'b1);
      apply_stimulus(2'b00, 32'h0000_0001, 5'd4);
      wait_done("b2b", 2'b00, 32'h0000_0001, 4, 1'b0);
      check_output("b2b const", data_o, 32'h0000_0010);
      idle_gap("b2b");

      $display("[TB] op 11 by 1");
      apply_stimulus(2'b11, 32'h8000_0001, 5'd1);
      wait_done("op11", 2'b11, 32'h8000_0001, 1, 1'b0);
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
      check_output("op11 const", data_o, 32'h0000_0003);
`else
      check_output("op11 const", data_o, 32'h0000_0002);
`endif
      idle_gap("op11");

      $display("[TB] reset mid-shift");
      apply_stimulus(2'b00, 32'h0000_0001, 5'd31);
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (5) @(posedge clk_i);
      #1;
      check_output("midrst busy before", 32'(busy_o), 32'd1);
      #2;
      rst_i = 1'b0;
      #1;
      check_output("midrst busy", 32'(busy_o), 32'd0);
      check_output("midrst done", 32'(done_o), 32'd0);
      check_output("midrst data", data_o, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
      saw_done = 1'b0;
      repeat (20) begin
         @(posedge clk_i); #1;
         if (done_o || busy_o) saw_done = 1'b1;
      end
      check_output("midrst no done after", 32'(saw_done), 32'd0);

      $display("[TB] randomized operations");
      chained = 1'b0;
      for (int i = 0; i < 24; i++) begin
         r_op    = 2'($urandom_range(0, 3));
         r_data  = $urandom;
         r_shamt = 5'($urandom_range(0, 31));
         r_hold  = 1'($urandom_range(0, 1));
         apply_stimulus(r_op, r_data, r_shamt);
         wait_done($sformatf("rand%0d", i), r_op, r_data, int'(r_shamt), r_hold);
         chained = 1'($urandom_range(0, 1));
         if (!chained) idle_gap($sformatf("rand%0d", i));
      end
      if (chained) idle_gap("rand tail");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
